// File: rtl/dispense_sequencer.sv
`timescale 1ns/1ps
// Candy dispenser sequencer: captures a Pi request, then drives carousel stepper,
// auger DC motor and servo gate strictly one at a time.
module dispense_sequencer #(
    parameter int STEP_DIV       = 6000,
    parameter int STEPS_PER_SLOT = 200,
    parameter int DC_TICKS       = 1200000,
    parameter int SERVO_TICKS    = 6000000
) (
    input  logic       clk_x1,
    input  logic       rstn,
    input  logic [2:0] sel_state,
    input  logic [1:0] amount,
    input  logic       candy_flag,
    output logic       sig_received,
    output logic       step_pulse,
    output logic       step_dir,
    output logic [1:0] dc_motor,
    output logic       servo_open,
    output logic       busy,
    output logic       done
);
    localparam int MAX_STEPS = 7 * STEPS_PER_SLOT;
    localparam int STEP_W    = ($clog2(MAX_STEPS + 1) > 11) ? $clog2(MAX_STEPS + 1) : 11;
    localparam int MAX_T01   = (STEP_DIV > DC_TICKS) ? STEP_DIV : DC_TICKS;
    localparam int MAX_T     = (MAX_T01 > SERVO_TICKS) ? MAX_T01 : SERVO_TICKS;
    localparam int TMR_W     = ($clog2(MAX_T) < 1) ? 1 : $clog2(MAX_T);

    localparam logic [TMR_W-1:0] DIV_LAST  = TMR_W'(STEP_DIV - 1);
    localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(STEP_DIV / 2 - 1);
    localparam logic [TMR_W-1:0] DC_LAST   = TMR_W'(DC_TICKS - 1);
    localparam logic [TMR_W-1:0] SV_LAST   = TMR_W'(SERVO_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MOVE, S_AUGER, S_GATE_OPEN, S_GATE_CLOSE, S_DONE
    } state_t;

    state_t            state;
    logic              flag_p0, flag_p1, flag_p2;
    logic [2:0]        pos, tgt;
    logic [1:0]        cnt;
    logic [STEP_W-1:0] steps_left;
    logic [TMR_W-1:0]  tmr;
    logic              request;
    logic              move_end;

    function automatic logic [STEP_W-1:0] slot_steps(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] d;
        d = (a > b) ? (a - b) : (b - a);
        return STEP_W'(d) * STEP_W'(STEPS_PER_SLOT);
    endfunction

    assign request = flag_p1 & ~flag_p2;

    // Motion ends on a zero-length move or on the falling edge of the last step.
    always_comb begin
        move_end = 1'b0;
        if (state == S_MOVE)
            move_end = (steps_left == '0) || ((tmr == DIV_LAST) && (steps_left == STEP_W'(1)));
    end

    always_ff @(posedge clk_x1 or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            flag_p0      <= 1'b0;
            flag_p1      <= 1'b0;
            flag_p2      <= 1'b0;
            pos          <= '0;
            tgt          <= '0;
            cnt          <= '0;
            steps_left   <= '0;
            tmr          <= '0;
            sig_received <= 1'b0;
            step_pulse   <= 1'b0;
            step_dir     <= 1'b0;
            dc_motor     <= 2'b00;
            servo_open   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            flag_p0 <= candy_flag;
            flag_p1 <= flag_p0;
            flag_p2 <= flag_p1;
            case (state)
                S_IDLE: begin
                    if (sig_received) begin
                        if (!flag_p1) sig_received <= 1'b0;
                    end else if (request) begin
                        tgt          <= sel_state;
                        cnt          <= amount;
                        sig_received <= 1'b1;
                        busy         <= 1'b1;
                        tmr          <= '0;
                        if (amount == 2'd0 && sel_state != 3'd0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            step_dir   <= (sel_state > pos);
                            steps_left <= slot_steps(sel_state, pos);
                            state      <= S_MOVE;
                        end
                    end
                end
                S_MOVE: begin
                    if (steps_left != '0) begin
                        if (tmr == DIV_LAST) begin
                            tmr        <= '0;
                            step_pulse <= 1'b0;
                            steps_left <= steps_left - 1'b1;
                        end else begin
                            if (tmr == HALF_LAST) step_pulse <= 1'b1;
                            tmr <= tmr + 1'b1;
                        end
                    end
                    if (move_end) begin
                        pos <= tgt;
                        tmr <= '0;
                        if (tgt == 3'd0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            dc_motor <= 2'b01;
                            state    <= S_AUGER;
                        end
                    end
                end
                S_AUGER: begin
                    if (tmr == DC_LAST) begin
                        tmr        <= '0;
                        dc_motor   <= 2'b00;
                        servo_open <= 1'b1;
                        state      <= S_GATE_OPEN;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_GATE_OPEN: begin
                    if (tmr == SV_LAST) begin
                        tmr        <= '0;
                        servo_open <= 1'b0;
                        state      <= S_GATE_CLOSE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_GATE_CLOSE: begin
                    if (tmr == SV_LAST) begin
                        tmr <= '0;
                        cnt <= cnt - 1'b1;
                        if (cnt == 2'd1) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            dc_motor <= 2'b01;
                            state    <= S_AUGER;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dispense_sequencer.sv
`timescale 1ns/1ps
// Bench for dispense_sequencer: directed and random requests compared against a
// slot-position model that predicts pulses, dispense counts and busy length.
module tb_dispense_sequencer;
    localparam int STEP_DIV = 4;
    localparam int SPS      = 2;
    localparam int DC       = 5;
    localparam int SERVO    = 3;

    logic       clk_x1 = 1'b0;
    logic       rstn;
    logic [2:0] sel_state;
    logic [1:0] amount;
    logic       candy_flag;
    logic       sig_received, step_pulse, step_dir, servo_open, busy, done;
    logic [1:0] dc_motor;

    int n_checks  = 0;
    int n_pass    = 0;
    int n_fail    = 0;
    int pos_model = 0;

    dispense_sequencer #(
        .STEP_DIV(STEP_DIV), .STEPS_PER_SLOT(SPS), .DC_TICKS(DC), .SERVO_TICKS(SERVO)
    ) dut (
        .clk_x1(clk_x1), .rstn(rstn), .sel_state(sel_state), .amount(amount),
        .candy_flag(candy_flag), .sig_received(sig_received), .step_pulse(step_pulse),
        .step_dir(step_dir), .dc_motor(dc_motor), .servo_open(servo_open),
        .busy(busy), .done(done)
    );

    always #5 clk_x1 = ~clk_x1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int outs_vec();
        return int'({sig_received, step_pulse, step_dir, dc_motor, servo_open, busy, done});
    endfunction

    // Issue one request and watch the whole sequence, comparing against the model.
    task automatic do_request(input int sel, input int amt, input bit glitch);
        bit   motion;
        int   exp_steps, exp_items, exp_busy, exp_dir;
        int   lat, pulses, dir_err, dc_runs, dc_cyc, sv_cyc, done_cnt, busy_cyc;
        int   excl_err, bad_dc, guard, act, spur;
        logic prev_step, prev_dc;

        motion    = !(amt == 0 && sel != 0);
        exp_steps = motion ? ((sel > pos_model) ? sel - pos_model : pos_model - sel) * SPS : 0;
        exp_dir   = (sel > pos_model) ? 1 : 0;
        exp_items = (motion && sel != 0) ? amt : 0;
        exp_busy  = (motion ? ((exp_steps != 0) ? exp_steps * STEP_DIV : 1) : 0)
                    + exp_items * (DC + 2 * SERVO) + 1;

        @(negedge clk_x1);
        sel_state  = 3'(sel);
        amount     = 2'(amt);
        candy_flag = 1'b1;
        lat = 0;
        while (!sig_received && lat < 10) begin
            @(negedge clk_x1);
            lat++;
        end
        check("ack_latency", int'(sig_received && lat <= 3), 1);
        sel_state = 3'($urandom);
        amount    = 2'($urandom);

        pulses = 0; dir_err = 0; dc_runs = 0; dc_cyc = 0; sv_cyc = 0; done_cnt = 0;
        busy_cyc = 0; excl_err = 0; bad_dc = 0; guard = 0;
        prev_step = 1'b0; prev_dc = 1'b0;
        while (busy && guard < 3000) begin
            if (step_pulse && !prev_step) begin
                pulses++;
                if (step_dir !== exp_dir[0]) dir_err++;
            end
            if (dc_motor == 2'b01) begin
                dc_cyc++;
                if (!prev_dc) dc_runs++;
            end
            if (dc_motor[1]) bad_dc++;
            if (servo_open) sv_cyc++;
            if (done) done_cnt++;
            act = int'(step_pulse) + int'(dc_motor != 2'b00) + int'(servo_open);
            if (act > 1) excl_err++;
            if (glitch && dc_runs == 1 && dc_cyc == 1) candy_flag = 1'b0;
            if (glitch && dc_runs == 1 && dc_cyc == 3) candy_flag = 1'b1;
            busy_cyc++;
            prev_step = step_pulse;
            prev_dc   = (dc_motor == 2'b01);
            @(negedge clk_x1);
            guard++;
        end
        candy_flag = 1'b1;

        check("step_pulses", pulses, exp_steps);
        check("step_dir_errors", dir_err, 0);
        check("dc_runs", dc_runs, exp_items);
        check("dc_cycles", dc_cyc, exp_items * DC);
        check("servo_cycles", sv_cyc, exp_items * SERVO);
        check("done_pulses", done_cnt, 1);
        check("busy_cycles", busy_cyc, exp_busy);
        check("exclusive_errors", excl_err, 0);
        check("dc_illegal", bad_dc, 0);
        check("ack_hold", int'(sig_received), 1);

        candy_flag = 1'b0;
        lat = 0;
        while (sig_received && lat < 8) begin
            @(negedge clk_x1);
            lat++;
        end
        check("ack_release", int'(!sig_received && lat <= 3), 1);
        spur = 0;
        repeat (5) begin
            @(negedge clk_x1);
            if (busy || done || sig_received) spur++;
        end
        check("no_requeue", spur, 0);
        if (motion) pos_model = sel;
    endtask

    initial begin
        int nz;
        int guard;
        rstn       = 1'b0;
        sel_state  = 3'd0;
        amount     = 2'd0;
        candy_flag = 1'b0;
        repeat (3) @(negedge clk_x1);
        check("reset_outputs", outs_vec(), 0);
        rstn = 1'b1;
        nz = 0;
        repeat (20) begin
            @(negedge clk_x1);
            if (outs_vec() != 0) nz++;
        end
        check("idle_quiet", nz, 0);

        do_request(3, 2, 1'b0);
        do_request(1, 1, 1'b0);
        do_request(0, 2, 1'b0);
        do_request(5, 0, 1'b0);
        do_request(2, 3, 1'b1);

        // Abort a move with reset and confirm the next request starts from slot 0.
        @(negedge clk_x1);
        sel_state  = 3'd6;
        amount     = 2'd1;
        candy_flag = 1'b1;
        guard = 0;
        while (!step_pulse && guard < 100) begin
            @(negedge clk_x1);
            guard++;
        end
        check("move_started", int'(step_pulse), 1);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset_outputs", outs_vec(), 0);
        candy_flag = 1'b0;
        repeat (3) @(negedge clk_x1);
        check("reset_held_outputs", outs_vec(), 0);
        rstn = 1'b1;
        pos_model = 0;
        repeat (3) @(negedge clk_x1);
        do_request(2, 1, 1'b0);

        for (int i = 0; i < 10; i++)
            do_request(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
